pulse_stream_arbiter: RTL

Round-robin arbiter that merges the per-line timestamp streams (32-bit words `{line_id[3:0], ts[27:0]}`) from up to 16 pulse timestamper FIFOs into one packetised AXI-Stream toward the DMA/packetiser. It grants one line at a time for a bounded burst and enforces per-line enable masking. Disabled lines are drained and their words counted as dropped, so a stalled line never blocks the others. Output words carry `tlast` every `PKT_LEN` words.

---
 rtl/pulse_stream_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pulse_stream_arbiter.sv
// Round-robin merge of per-line timestamp streams into one packetised AXI-Stream.
// Disabled lines are drained and counted so they can never stall the output.
module pulse_stream_arbiter #(
   parameter int NUM_LINES = 8,
   parameter int MAX_BURST = 4,
   parameter int PKT_LEN   = 256
) (
   input  logic                    sample_clk,
   input  logic                    resetn,
   input  logic                    run,
   input  logic [NUM_LINES-1:0]    line_en,
   input  logic [32*NUM_LINES-1:0] s_tdata,
   input  logic [NUM_LINES-1:0]    s_tvalid,
   output logic [NUM_LINES-1:0]    s_tready,
   output logic [31:0]             m_tdata,
   output logic                    m_tvalid,
   output logic                    m_tlast,
   input  logic                    m_tready,
   output logic [15:0]             drop_count,
   output logic                    busy
);

   localparam int GW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

   typedef enum logic {IDLE, BURST} state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] g_q, g_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic [7:0]    bc_q, bc_d;
   logic [15:0]   pkt_cnt_q, pkt_cnt_d;
   logic [31:0]   m_tdata_q, m_tdata_d;
   logic          m_tvalid_q, m_tvalid_d;
   logic          m_tlast_q, m_tlast_d;
   logic [15:0]   drop_count_q, drop_count_d;

   logic [NUM_LINES-1:0] req;
   logic [GW-1:0]        rr_sel;
   logic [31:0]          g_data;
   logic                 g_valid;
   logic                 g_en;
   logic                 out_free;
   logic                 load;
   logic [4:0]           n_drop;
   logic [16:0]          drop_sum;

   assign req      = s_tvalid & line_en;
   assign g_data   = s_tdata[32*int'(g_q) +: 32];
   assign g_valid  = s_tvalid[g_q];
   assign g_en     = line_en[g_q];
   assign out_free = !m_tvalid_q || m_tready;
   assign load     = (state_q == BURST) && g_en && g_valid && out_free;

   // First requester above ptr: scan from the far end so the nearest hit wins.
   // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
   always_comb begin
      rr_sel = ptr_q;
      for (int k = NUM_LINES; k >= 1; k--) begin
         if (req[(int'(ptr_q) + k) % NUM_LINES]) rr_sel = GW'((int'(ptr_q) + k) % NUM_LINES);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_LINES; i++) begin
         s_tready[i] = !line_en[i] || ((state_q == BURST) && (g_q == GW'(i)) && out_free);
      end
   end

   always_comb begin
      n_drop = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         n_drop = n_drop + 5'(s_tvalid[i] & ~line_en[i]);
      end
      drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      ptr_d      = ptr_q;
      bc_d       = bc_q;
      pkt_cnt_d  = pkt_cnt_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;

      case (state_q)
         IDLE: begin
            if (run && (|req)) begin
               state_d = BURST;
               g_d     = rr_sel;
               ptr_d   = rr_sel;
               bc_d    = '0;
            end
         end
         BURST: begin
            if (load) bc_d = bc_q + 8'd1;
            if ((load && (bc_q == 8'(MAX_BURST - 1))) || !g_valid || !g_en) state_d = IDLE;
         end
      endcase

      if (load) begin
         m_tdata_d  = g_data;
         m_tvalid_d = 1'b1;
         m_tlast_d  = (pkt_cnt_q == 16'(PKT_LEN - 1));
         pkt_cnt_d  = m_tlast_d ? 16'd0 : pkt_cnt_q + 16'd1;
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sample_clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         g_q          <= '0;
         ptr_q        <= GW'(NUM_LINES - 1);
         bc_q         <= '0;
         pkt_cnt_q    <= '0;
         m_tdata_q    <= '0;
         m_tvalid_q   <= 1'b0;
         m_tlast_q    <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         ptr_q        <= ptr_d;
         bc_q         <= bc_d;
         pkt_cnt_q    <= pkt_cnt_d;
         m_tdata_q    <= m_tdata_d;
         m_tvalid_q   <= m_tvalid_d;
         m_tlast_q    <= m_tlast_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign m_tdata    = m_tdata_q;
   assign m_tvalid   = m_tvalid_q;
   assign m_tlast    = m_tlast_q;
   assign drop_count = drop_count_q;
   assign busy       = (state_q == BURST) || m_tvalid_q;

endmodule
